// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word loads and stores into single-word
// accesses on a combinational-read, edge-write data memory.
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 8192
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    RMW_RD = 3'd2,
    WRITE  = 3'd3,
    RESP   = 3'd4
  } state_e;

  localparam logic [1:0]  SZ_BYTE    = 2'b00;
  localparam logic [1:0]  SZ_HALF    = 2'b01;
  localparam logic [1:0]  SZ_WORD    = 2'b10;
  localparam logic [31:0] ADDR_LIMIT = 32'(MEM_BYTES);

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  // Holds the store word: raw wdata on accept, merged word after RMW_RD.
  logic [31:0] word_q, word_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  function automatic logic is_fault(input logic [1:0] size, input logic [31:0] addr);
    logic f;
    case (size)
      SZ_BYTE: f = 1'b0;
      SZ_HALF: f = addr[0];
      SZ_WORD: f = (addr[1:0] != 2'b00);
      default: f = 1'b1;
    endcase
    return f || (addr >= ADDR_LIMIT);
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    if (lane[1]) begin
      h = word[31:16];
    end else begin
      h = word[15:0];
    end
    case (size)
      SZ_BYTE: r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      SZ_WORD: r = word;
      default: r = 32'h0000_0000;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] old, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lane);
    logic [31:0] r;
    case (size)
      SZ_BYTE: begin
        case (lane)
          2'd0:    r = {old[31:8], wdata[7:0]};
          2'd1:    r = {old[31:16], wdata[7:0], old[7:0]};
          2'd2:    r = {old[31:24], wdata[7:0], old[15:0]};
          default: r = {wdata[7:0], old[23:0]};
        endcase
      end
      SZ_HALF: begin
        if (lane[1]) begin
          r = {wdata[15:0], old[15:0]};
        end else begin
          r = {old[31:16], wdata[15:0]};
        end
      end
      default: r = wdata;
    endcase
    return r;
  endfunction

  // Next-state, operand latching and response computation.
  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    word_d      = word_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d      = req_size;
          uns_d       = req_unsigned;
          addr_d      = req_addr;
          word_d      = req_wdata;
          rsp_rdata_d = 32'h0000_0000;
          if (is_fault(req_size, req_addr)) begin
            rsp_err_d   = 1'b1;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else if (!req_we) begin
            rsp_err_d = 1'b0;
            state_d   = LOAD;
          end else if (req_size == SZ_WORD) begin
            rsp_err_d = 1'b0;
            state_d   = WRITE;
          end else begin
            rsp_err_d = 1'b0;
            state_d   = RMW_RD;
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        rsp_rdata_d = load_extend(mem_rdata, size_q, addr_q[1:0], uns_q);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RMW_RD: begin
        word_d  = merge_store(mem_rdata, word_q, size_q, addr_q[1:0]);
        state_d = WRITE;
      end
      WRITE: begin
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        rsp_rdata_d = 32'h0000_0000;
        rsp_err_d   = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= 32'h0000_0000;
      word_q      <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'h0000_0000;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Memory-side strobes decoded from registered state only.
  always_comb begin
    req_ready = (state_q == IDLE);
    mem_read  = (state_q == LOAD) || (state_q == RMW_RD);
    mem_write = (state_q == WRITE);
    if (mem_read || mem_write) begin
      mem_addr = {addr_q[31:2], 2'b00};
    end else begin
      mem_addr = 32'h0000_0000;
    end
    if (mem_write) begin
      mem_wdata = word_q;
    end else begin
      mem_wdata = 32'h0000_0000;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
